weight_buffer: RTL

//  Ping-pong on-chip weight store sitting directly upstream of the weight dispatcher.

---
 rtl/weight_buf_pkg.sv | 19 +
 rtl/weight_buffer_if.sv | 42 ++++
 rtl/wbuf_bank.sv | 26 ++
 rtl/weight_buffer.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/weight_buf_pkg.sv
// Shared constants and types for the weight buffer and its dispatcher.
//   LINE_W / BEAT_W / ADDR_W : line width, DMA beat width, line address width
//   BEATS_PER_LINE            : DMA beats assembled into one line (must be >= 2)
//   load_state_e              : load FSM encoding
package weight_buf_pkg;
    localparam int LINE_W         = 4096;
    localparam int BEAT_W         = 512;
    localparam int ADDR_W         = 8;
    localparam int DEPTH          = 2 ** ADDR_W;
    localparam int BEATS_PER_LINE = LINE_W / BEAT_W;
    localparam int BEAT_CNT_W     = (BEATS_PER_LINE > 1) ? $clog2(BEATS_PER_LINE) : 1;
    // Holds every beat of a line except the last, which is written straight from the bus.
    localparam int ASM_W          = LINE_W - BEAT_W;

    typedef enum logic {
        L_IDLE = 1'b0,
        L_FILL = 1'b1
    } load_state_e;
endpackage

// File: rtl/weight_buffer_if.sv
// Bus bundle for weight_buffer: load control, DMA beat stream, swap control,
// dispatcher read port and a debug view of the load FSM.
//   master : upstream controller / DMA / dispatcher side
//   slave  : weight_buffer
//
// DMA handshake: a beat transfers on a rising clk edge where dma_valid and
// dma_ready are both 1. dma_valid/dma_data are driven by the master and may
// change freely while no transfer occurs; dma_ready depends only on the load
// FSM state, never combinationally on dma_valid.
interface weight_buffer_if;
    import weight_buf_pkg::*;

    logic                cfg_load_start;
    logic [ADDR_W-1:0]   cfg_load_base;
    logic [ADDR_W:0]     cfg_load_lines;
    logic                cfg_swap;
    logic                dma_valid;
    logic                dma_ready;
    logic [BEAT_W-1:0]   dma_data;
    logic                load_busy;
    logic                load_done;
    logic                serve_bank;
    logic                rd_en;
    logic [ADDR_W-1:0]   rd_addr;
    logic [LINE_W-1:0]   rd_data;
    logic                rd_valid;
    load_state_e         load_state;

    modport master (
        output cfg_load_start, cfg_load_base, cfg_load_lines, cfg_swap,
        output dma_valid, dma_data, rd_en, rd_addr,
        input  dma_ready, load_busy, load_done, serve_bank, rd_data, rd_valid,
        input  load_state
    );

    modport slave (
        input  cfg_load_start, cfg_load_base, cfg_load_lines, cfg_swap,
        input  dma_valid, dma_data, rd_en, rd_addr,
        output dma_ready, load_busy, load_done, serve_bank, rd_data, rd_valid,
        output load_state
    );
endinterface

// File: rtl/wbuf_bank.sv
// One weight bank: DEPTH x LINE_W simple dual-port RAM, one write port and one
// read port with a single-cycle registered read. Contents are not reset.
//   we_i/waddr_i/wdata_i : write port
//   re_i/raddr_i         : read request; rdata_o updates on the next edge
//   rdata_o              : holds its value while re_i is low
module wbuf_bank
    import weight_buf_pkg::*;
(
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [LINE_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [LINE_W-1:0] rdata_o
);
    logic [LINE_W-1:0] mem_q [DEPTH];
    logic [LINE_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/weight_buffer.sv
// Ping-pong weight store. DMA beats are assembled into lines and written into
// the fill bank (~serve_bank) while the dispatcher reads the serve bank with a
// fixed one-cycle latency. Banks exchange on cfg_swap; a swap requested during
// a load is held until the load's last line commits.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : weight_buffer_if.slave (load control, DMA, swap, reads, FSM view)
module weight_buffer
    import weight_buf_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    weight_buffer_if.slave bus
);
    load_state_e           state_q, state_d;
    logic [BEAT_CNT_W-1:0] beat_q, beat_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [ADDR_W:0]       left_q, left_d;
    logic [ASM_W-1:0]      asm_q, asm_d;
    logic                  done_q, done_d;
    logic                  serve_q, serve_d;
    logic                  pend_q, pend_d;
    logic                  rd_valid_q, rd_sel_q, rd_seen_q;
    logic                  line_we, last_beat;
    logic [LINE_W-1:0]     line_wdata;
    logic [LINE_W-1:0]     rdata0, rdata1;

    assign last_beat  = (beat_q == BEAT_CNT_W'(BEATS_PER_LINE - 1));
    // The final beat goes straight to the RAM, so the line commits in the same cycle.
    assign line_wdata = {bus.dma_data, asm_q};

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        addr_d  = addr_q;
        left_d  = left_q;
        asm_d   = asm_q;
        done_d  = 1'b0;
        serve_d = serve_q;
        pend_d  = pend_q;
        line_we = 1'b0;
        case (state_q)
            L_IDLE: begin
                if (bus.cfg_swap) serve_d = ~serve_q;
                if (bus.cfg_load_start) begin
                    if (bus.cfg_load_lines != '0) begin
                        state_d = L_FILL;
                        addr_d  = bus.cfg_load_base;
                        left_d  = bus.cfg_load_lines;
                        beat_d  = '0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            L_FILL: begin
                // Only one swap is remembered; repeats while pending collapse into it.
                if (bus.cfg_swap) pend_d = 1'b1;
                if (bus.dma_valid) begin
                    if (last_beat) begin
                        line_we = 1'b1;
                        beat_d  = '0;
                        addr_d  = addr_q + 1'b1;
                        left_d  = left_q - 1'b1;
                        if (left_q == {{ADDR_W{1'b0}}, 1'b1}) begin
                            state_d = L_IDLE;
                            done_d  = 1'b1;
                            pend_d  = 1'b0;
                            if (pend_q || bus.cfg_swap) serve_d = ~serve_q;
                        end
                    end else begin
                        beat_d = beat_q + 1'b1;
                        asm_d[int'(beat_q) * BEAT_W +: BEAT_W] = bus.dma_data;
                    end
                end
            end
            default: state_d = L_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= L_IDLE;
            beat_q  <= '0;
            addr_q  <= '0;
            left_q  <= '0;
            asm_q   <= '0;
            done_q  <= 1'b0;
            serve_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
            left_q  <= left_d;
            asm_q   <= asm_d;
            done_q  <= done_d;
            serve_q <= serve_d;
            pend_q  <= pend_d;
        end
    end

    // The bank select is captured with the request so a swap in the same
    // cycle still returns the old serve bank. rd_seen_q keeps rd_data at
    // zero until the first read after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_sel_q   <= 1'b0;
            rd_seen_q  <= 1'b0;
        end else begin
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) begin
                rd_sel_q  <= serve_q;
                rd_seen_q <= 1'b1;
            end
        end
    end

    wbuf_bank u_bank0 (
        .clk     (clk),
        .we_i    (line_we && serve_q),
        .waddr_i (addr_q),
        .wdata_i (line_wdata),
        .re_i    (bus.rd_en && !serve_q),
        .raddr_i (bus.rd_addr),
        .rdata_o (rdata0)
    );

    wbuf_bank u_bank1 (
        .clk     (clk),
        .we_i    (line_we && !serve_q),
        .waddr_i (addr_q),
        .wdata_i (line_wdata),
        .re_i    (bus.rd_en && serve_q),
        .raddr_i (bus.rd_addr),
        .rdata_o (rdata1)
    );

    assign bus.dma_ready  = (state_q == L_FILL);
    assign bus.load_busy  = (state_q == L_FILL);
    assign bus.load_done  = done_q;
    assign bus.serve_bank = serve_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_data    = rd_seen_q ? (rd_sel_q ? rdata1 : rdata0) : '0;
    assign bus.load_state = state_q;
endmodule
